led_pattern_ctrl: RTL and testbench

- Upstream drive stage for the board LED output `led_r`; replaces the static tie-high with a user-selectable pattern.
- A raw push-button is synchronised and debounced; each debounced press advances a 4-mode FSM: OFF, ON, BLINK, BREATHE.
- Output is a registered single-bit LED drive; BREATHE uses PWM with a triangular duty ramp.

---
 rtl/led_pattern_ctrl.sv | 179 +++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// Board LED pattern driver: debounced push-button steps OFF -> ON -> BLINK -> BREATHE.
// Define LED_GAMMA_EN to square the BREATHE duty ramp for perceptually linear brightness.
module led_pattern_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter int unsigned BLINK_HALF_CYCLES   = 25000000,
    parameter int unsigned PWM_BITS            = 8,
    parameter int unsigned BREATHE_STEP_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       led_r,
    output logic [1:0] mode,
    output logic       mode_change
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned BL_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam int unsigned ST_W = (BREATHE_STEP_CYCLES > 1) ? $clog2(BREATHE_STEP_CYCLES) : 1;

    localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0]     BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [ST_W-1:0]     ST_LAST = ST_W'(BREATHE_STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    mode_e               state;
    mode_e               state_next;
    logic [1:0]          sync_q;
    logic                btn_s;
    logic                stable;
    logic                stable_d;
    logic                press;
    logic [DB_W-1:0]     db_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [ST_W-1:0]     step_cnt;
    logic [PWM_BITS-1:0] ramp;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic                dir_down;
    logic                led_int;

    always_comb begin
        btn_s = sync_q[1];
        press = stable & ~stable_d;
    end

    // Synchroniser and debounce; stable_d turns the stable rise into a one-cycle press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn};
            stable_d <= stable;
            if (btn_s == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MODE_OFF;
            mode_change <= 1'b0;
        end else begin
            state       <= state_next;
            mode_change <= press;
        end
    end

    always_comb begin
        state_next = state;
        if (press) begin
            case (state)
                MODE_OFF:     state_next = MODE_ON;
                MODE_ON:      state_next = MODE_BLINK;
                MODE_BLINK:   state_next = MODE_BREATHE;
                MODE_BREATHE: state_next = MODE_OFF;
                default:      state_next = MODE_OFF;
            endcase
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] ramp_sq;
    always_comb begin
        ramp_sq   = {{PWM_BITS{1'b0}}, ramp} * {{PWM_BITS{1'b0}}, ramp};
        duty_next = ramp_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        duty_next = ramp;
    end
`endif

    // Pattern state; a press reloads entry values ahead of any counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            ramp      <= '0;
            duty      <= '0;
            dir_down  <= 1'b0;
        end else if (press) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            ramp      <= '0;
            duty      <= '0;
            dir_down  <= 1'b0;
        end else begin
            if (state == MODE_BLINK) begin
                if (blink_cnt == BL_LAST) begin
                    blink_cnt <= '0;
                    blink_q   <= ~blink_q;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (state == MODE_BREATHE) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == PWM_MAX) begin
                    duty <= duty_next;
                end
                if (step_cnt == ST_LAST) begin
                    step_cnt <= '0;
                    // Direction flips with the ramp held, giving a one-step dwell at each end.
                    if (!dir_down) begin
                        if (ramp == PWM_MAX) dir_down <= 1'b1;
                        else                 ramp     <= ramp + 1'b1;
                    end else begin
                        if (ramp == '0) dir_down <= 1'b0;
                        else            ramp     <= ramp - 1'b1;
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_int = 1'b0;
        case (state)
            MODE_OFF:     led_int = 1'b0;
            MODE_ON:      led_int = 1'b1;
            MODE_BLINK:   led_int = blink_q;
            MODE_BREATHE: led_int = (pwm_cnt < duty);
            default:      led_int = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_r <= 1'b0;
        else        led_r <= led_int;
    end

    assign mode = state;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised bench for led_pattern_ctrl against a closed-form model of the mode sequence
// and LED patterns (BLINK square wave, BREATHE triangle ramp sampled at PWM period boundaries).
module tb_led_pattern_ctrl;

    localparam int DEB  = 4;
    localparam int BH   = 5;
    localparam int PB   = 4;
    localparam int STEP = 2;
    localparam int PER  = 16;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       led_r;
    logic [1:0] mode;
    logic       mode_change;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state
    logic       m_s1, m_s2, m_stable, m_rise, m_mc, m_led;
    int         m_run;
    logic [1:0] m_mode;
    int         m_te;

    led_pattern_ctrl #(
        .DEBOUNCE_CYCLES    (DEB),
        .BLINK_HALF_CYCLES  (BH),
        .PWM_BITS           (PB),
        .BREATHE_STEP_CYCLES(STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .led_r      (led_r),
        .mode       (mode),
        .mode_change(mode_change)
    );

    always #5 clk = ~clk;

    // Triangle ramp after k steps: 0..MAX, MAX, MAX-1..0, 0, 1, ...
    function automatic int ramp_at(input int k);
        int p;
        p = k % (2 * MAXV + 2);
        return (p <= MAXV) ? p : (2 * MAXV + 1 - p);
    endfunction

    // Duty in force during PWM period j after BREATHE entry.
    function automatic int exp_duty(input int j);
        int r;
        if (j == 0) return 0;
        r = ramp_at((PER * j - 1) / STEP);
`ifdef LED_GAMMA_EN
        return (r * r) >> PB;
`else
        return r;
`endif
    endfunction

    // Internal LED value t cycles after entering mode md.
    function automatic logic model_led(input logic [1:0] md, input int t);
        case (md)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return ((t / BH) % 2) == 0;
            default: return (t % PER) < exp_duty(t / PER);
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_rise = 0; m_mc = 0; m_led = 0;
        m_run = 0; m_mode = 2'd0; m_te = cyc;
    endtask

    task automatic tick(input logic b);
        logic press;
        btn = b;
        @(posedge clk);
        #1;
        cyc++;
        m_led = model_led(m_mode, cyc - 1 - m_te);
        press = m_rise;
        m_rise = 0;
        if (m_s2 != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = m_s2;
                m_run = 0;
                m_rise = m_s2;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_mc = press;
        if (press) begin
            m_mode = m_mode + 2'd1;
            m_te = cyc;
        end
    endtask

    task automatic test_reset();
        btn = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (led_r !== 1'b0 || mode !== 2'd0 || mode_change !== 1'b0)
            $display("FAIL reset_state led_r=%b mode=%0d mode_change=%b required 0/0/0", led_r, mode, mode_change);
        else n_pass++;
        rst_n = 1;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL reset_idle cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        for (int i = 1; i <= 100; i++) begin
            tick(1'b1);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL press_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
            if (i == 6 || i == 7 || i == 8) begin
                n_checks++;
                if (mode !== ((i >= 7) ? 2'd1 : 2'd0) || mode_change !== (i == 7) || led_r !== (i == 8))
                    $display("FAIL press_latency i=%0d mode=%0d mc=%b led_r=%b", i, mode, mode_change, led_r);
                else n_pass++;
            end
        end
        n_checks++;
        if (mode !== 2'd1) $display("FAIL press_hold mode=%0d required 1", mode);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL press_release cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 40; i++) begin
            tick((i % 4) != 3);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL bounce_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
        end
        n_checks++;
        if (mode !== 2'd1) $display("FAIL bounce_ignored mode=%0d required 1", mode);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL bounce_hold cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
        end
        n_checks++;
        if (mode !== 2'd2) $display("FAIL bounce_advance mode=%0d required 2", mode);
        else n_pass++;
    endtask

    task automatic test_blink();
        int k;
        logic want;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL blink_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
            k = cyc - m_te - 1;
            if (k >= 0 && k < 20) begin
                want = (k < 5) || (k >= 10 && k < 15);
                n_checks++;
                if (led_r !== want) $display("FAIL blink_phase k=%0d led_r=%b required %b", k, led_r, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_breathe();
        logic got = 0;
        int hi, k, te;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(1'b1);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL breathe_press cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
            got = mode_change;
        end
        n_checks++;
        if (!got || mode !== 2'd3) $display("FAIL breathe_enter mode=%0d required 3", mode);
        else n_pass++;
        te = cyc;
        hi = 0;
        for (int i = 0; i < PER * 70; i++) begin
            tick(1'b0);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL breathe_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
            k = cyc - te - 1;
            hi += (led_r === 1'b1) ? 1 : 0;
            if (k % PER == PER - 1) begin
                n_checks++;
                if (hi !== exp_duty(k / PER))
                    $display("FAIL breathe_duty period=%0d high=%0d required %0d", k / PER, hi, exp_duty(k / PER));
                else n_pass++;
                hi = 0;
            end
        end
    endtask

    task automatic test_wrap();
        int presses = 0;
        logic got;
        for (int p = 0; p < 4; p++) begin
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                tick(1'b1);
                n_checks++;
                if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                    $display("FAIL wrap_press cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
                else n_pass++;
                got = mode_change;
            end
            presses += got ? 1 : 0;
            for (int i = 0; i < 18; i++) begin
                tick(1'b0);
                n_checks++;
                if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                    $display("FAIL wrap_idle cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
                else n_pass++;
                if (p == 0 && i == 0) begin
                    n_checks++;
                    if (mode !== 2'd0 || led_r !== 1'b0)
                        $display("FAIL wrap_to_off mode=%0d led_r=%b required 0/0", mode, led_r);
                    else n_pass++;
                end
                if (p == 3 && i < PER) begin
                    n_checks++;
                    if (led_r !== 1'b0) $display("FAIL wrap_duty_cleared i=%0d led_r=%b required 0", i, led_r);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (presses !== 4 || mode !== 2'd3) $display("FAIL wrap_count presses=%0d mode=%0d required 4/3", presses, mode);
        else n_pass++;
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 4; i++) tick(1'b1);
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if (led_r !== 1'b0 || mode !== 2'd0 || mode_change !== 1'b0)
            $display("FAIL midreset_async led_r=%b mode=%0d mc=%b required 0/0/0", led_r, mode, mode_change);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            n_checks++;
            if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                $display("FAIL midreset_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
            else n_pass++;
            if (i == 6 || i == 7) begin
                n_checks++;
                if (mode !== ((i == 7) ? 2'd1 : 2'd0)) $display("FAIL midreset_latency i=%0d mode=%0d", i, mode);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic b = 0;
        int len;
        int i = 0;
        while (i < 3000) begin
            b = ~b;
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) len = $urandom_range(20, 300);
            for (int j = 0; j < len; j++) begin
                tick(b);
                i++;
                n_checks++;
                if (led_r !== m_led || mode !== m_mode || mode_change !== m_mc)
                    $display("FAIL random_model cyc=%0d led_r=%b/%b mode=%0d/%0d mc=%b/%b", cyc, led_r, m_led, mode, m_mode, mode_change, m_mc);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_blink();
        test_breathe();
        test_wrap();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
